// File: rtl/spn_pkg.sv
// Shared constants, FSM encoding and key-rotation helper for the PRESENT-80
// round controller and its key-schedule sub-module.
package spn_pkg;

    localparam int ROUNDS  = 31;
    localparam int KEY_W   = 80;
    localparam int BLK_W   = 64;

    localparam int RK_HI   = 79;
    localparam int RK_LO   = 16;

    localparam int KEY_ROT = 61;

    localparam int RC_HI   = 19;
    localparam int RC_LO   = 15;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    // Rotating left by 61 on an 80-bit word is the same as rotating right by 19.
    function automatic logic [KEY_W-1:0] rotl_key(input logic [KEY_W-1:0] k);
        return (k << KEY_ROT) | (k >> (KEY_W - KEY_ROT));
    endfunction

endpackage

// File: rtl/spn_round_controller_if.sv
// Host-side and cipher-side handshake bundle for the round controller.
interface spn_round_controller_if;
    import spn_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] plaintext;
    logic [KEY_W-1:0] key;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] ciphertext;
    logic             busy;
    logic [4:0]       round_idx;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, round_idx
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, round_idx
    );

endinterface

// File: rtl/SBox.sv
// PRESENT 4-bit substitution box, purely combinational.
module SBox (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        case (din)
            4'h0:    dout = 4'hC;
            4'h1:    dout = 4'h5;
            4'h2:    dout = 4'h6;
            4'h3:    dout = 4'hB;
            4'h4:    dout = 4'h9;
            4'h5:    dout = 4'h0;
            4'h6:    dout = 4'hA;
            4'h7:    dout = 4'hD;
            4'h8:    dout = 4'h3;
            4'h9:    dout = 4'hE;
            4'hA:    dout = 4'hF;
            4'hB:    dout = 4'h8;
            4'hC:    dout = 4'h4;
            4'hD:    dout = 4'h7;
            4'hE:    dout = 4'h1;
            default: dout = 4'h2;
        endcase
    end

endmodule

// File: rtl/SubsLayer.sv
// 64-bit substitution layer: sixteen S-boxes applied to independent nibbles.
module SubsLayer (
    input  logic [63:0] din,
    output logic [63:0] dout
);

    for (genvar n = 0; n < 16; n++) begin : g_sbox
        SBox u_sbox (
            .din  (din[4*n +: 4]),
            .dout (dout[4*n +: 4])
        );
    end

endmodule

// File: rtl/present_key_update.sv
// One step of the PRESENT-80 key schedule: rotate, substitute the top nibble,
// then fold the round counter into bits 19:15.
module present_key_update
    import spn_pkg::*;
(
    input  logic [KEY_W-1:0] key_cur,
    input  logic [4:0]       rnd,
    output logic [KEY_W-1:0] key_next
);

    logic [KEY_W-1:0] rotated;
    logic [3:0]       top_nibble;

    assign rotated = rotl_key(key_cur);

    SBox u_sbox (
        .din  (rotated[KEY_W-1 -: 4]),
        .dout (top_nibble)
    );

    always_comb begin
        key_next                = rotated;
        key_next[KEY_W-1 -: 4]  = top_nibble;
        key_next[RC_HI:RC_LO]   = rotated[RC_HI:RC_LO] ^ rnd;
    end

endmodule

// File: rtl/spn_round_controller.sv
// Iterative PRESENT-80 encryption controller: one round per clock, 31 rounds
// followed by a final key whitening, with valid/ready handshakes on both sides.
module spn_round_controller
    import spn_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    spn_round_controller_if.slave bus
);

    fsm_t             fsm;
    logic [BLK_W-1:0] state_reg;
    logic [KEY_W-1:0] key_reg;
    logic [4:0]       round_idx;
    logic [BLK_W-1:0] ciphertext;
    logic             out_valid;
    logic             busy;

    logic [BLK_W-1:0] mixed;
    logic [BLK_W-1:0] subst;
    logic [BLK_W-1:0] perm;
    logic [KEY_W-1:0] key_next;

    assign mixed = state_reg ^ key_reg[RK_HI:RK_LO];

    SubsLayer u_subs (
        .din  (mixed),
        .dout (subst)
    );

    // Bit i moves to position 16*i mod 63; the MSB is a fixed point.
    for (genvar i = 0; i < BLK_W - 1; i++) begin : g_perm
        assign perm[(16 * i) % (BLK_W - 1)] = subst[i];
    end
    assign perm[BLK_W-1] = subst[BLK_W-1];

    present_key_update u_key (
        .key_cur  (key_reg),
        .rnd      (round_idx),
        .key_next (key_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= IDLE;
            state_reg  <= '0;
            key_reg    <= '0;
            round_idx  <= '0;
            ciphertext <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.plaintext;
                        key_reg   <= bus.key;
                        round_idx <= 5'd1;
                        busy      <= 1'b1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= perm;
                    key_reg   <= key_next;
                    // The last round still runs; the counter parks at 0 for FINAL.
                    if (round_idx == 5'(ROUNDS)) begin
                        round_idx <= '0;
                        fsm       <= FINAL;
                    end else begin
                        round_idx <= round_idx + 5'd1;
                    end
                end
                FINAL: begin
                    ciphertext <= mixed;
                    out_valid  <= 1'b1;
                    busy       <= 1'b0;
                    fsm        <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (fsm == IDLE);
    assign bus.out_valid  = out_valid;
    assign bus.ciphertext = ciphertext;
    assign bus.busy       = busy;
    assign bus.round_idx  = round_idx;

endmodule
